// File: rtl/fuzzy_sample_sequencer.sv
// ---------------------------------------------------------------------------
// fuzzy_sample_sequencer
//
// Front-end driver for the fuzzy flood-risk evaluator. Accepts a byte stream
// of alternating rain / soil-moisture samples, saturates each sample at
// MAX_LEVEL, and averages 2**AVG_LOG2 rain/soil pairs. The averages are
// presented on raw/sow, the evaluator is enabled for one cycle through ef,
// its registered risk byte is captured, and the result is returned to the
// consumer over a valid/ready handshake.
//
// Optional feature macro: FUZZ_RISK_ALARM_EN
//   defined   : alarm is a register updated on the CAPTURE edge with
//               (risk >= ALARM_LEVEL) and held until the next capture.
//   undefined : alarm is tied low and ALARM_LEVEL has no effect.
//
// Ports
//   clk       in   1  clock
//   rst_n     in   1  synchronous, active-low reset
//   s_data    in   8  sample byte (even index = rain, odd index = soil)
//   s_valid   in   1  s_data valid
//   s_ready   out  1  sample accepted this cycle when s_valid is high
//   raw       out  8  averaged rain level to evaluator (registered)
//   sow       out  8  averaged soil level to evaluator (registered)
//   ef        out  1  evaluator enable, one-cycle pulse
//   risk      in   8  evaluator's registered risk output
//   m_risk    out  8  captured risk result
//   m_valid   out  1  m_risk valid
//   m_ready   in   1  consumer accepts m_risk
//   busy      out  1  low only when idle (COLLECT_RAIN with no pairs taken)
//   alarm     out  1  risk alarm (see macro above)
//   dbg_state out  3  current FSM state, for observation
//
// Handshakes: a transfer happens at a rising edge where valid & ready are
// both high. Neither side may make valid depend on ready; the producer holds
// its data stable while valid is high and ready is low.
// ---------------------------------------------------------------------------
module fuzzy_sample_sequencer #(
  parameter int AVG_LOG2    = 2,
  parameter int MAX_LEVEL   = 100,
  parameter int ALARM_LEVEL = 170
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] raw,
  output logic [7:0] sow,
  output logic       ef,
  input  logic [7:0] risk,
  output logic [7:0] m_risk,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       alarm,
  output logic [2:0] dbg_state
);

  localparam int AW = 8 + AVG_LOG2;   // accumulator width, holds 2**AVG_LOG2 * 255
  localparam int CW = AVG_LOG2 + 1;   // pair counter must reach 2**AVG_LOG2
  localparam logic [CW-1:0] PAIRS = CW'(2 ** AVG_LOG2);
  localparam logic [7:0]    MAX_B = 8'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_COLLECT_RAIN = 3'd0,
    S_COLLECT_SOIL = 3'd1,
    S_EVAL         = 3'd2,
    S_CAPTURE      = 3'd3,
    S_OUTPUT       = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   sum_r_q, sum_r_d;
  logic [AW-1:0]   sum_s_q, sum_s_d;
  logic [7:0]      raw_q, raw_d;
  logic [7:0]      sow_q, sow_d;
  logic [7:0]      m_risk_q, m_risk_d;
  logic            m_valid_q, m_valid_d;

  logic [7:0]      sat;
  logic [AW-1:0]   sum_r_new;
  logic [AW-1:0]   sum_s_new;
  logic [CW-1:0]   cnt_inc;

  assign sat       = (s_data > MAX_B) ? MAX_B : s_data;
  assign sum_r_new = sum_r_q + AW'(sat);
  // Soil sum including the byte arriving now; the final average uses it.
  assign sum_s_new = sum_s_q + AW'(sat);
  assign cnt_inc   = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_COLLECT_RAIN;
      cnt_q     <= '0;
      sum_r_q   <= '0;
      sum_s_q   <= '0;
      raw_q     <= '0;
      sow_q     <= '0;
      m_risk_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_r_q   <= sum_r_d;
      sum_s_q   <= sum_s_d;
      raw_q     <= raw_d;
      sow_q     <= sow_d;
      m_risk_q  <= m_risk_d;
      m_valid_q <= m_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_r_d   = sum_r_q;
    sum_s_d   = sum_s_q;
    raw_d     = raw_q;
    sow_d     = sow_q;
    m_risk_d  = m_risk_q;
    m_valid_d = m_valid_q;
    case (state_q)
      S_COLLECT_RAIN: begin
        if (s_valid) begin
          sum_r_d = sum_r_new;
          state_d = S_COLLECT_SOIL;
        end
      end
      S_COLLECT_SOIL: begin
        if (s_valid) begin
          sum_s_d = sum_s_new;
          cnt_d   = cnt_inc;
          if (cnt_inc == PAIRS) begin
            // Truncating averages; the cast keeps the low byte, which is
            // exact because the shifted sum never exceeds 255.
            raw_d   = 8'(sum_r_q >> AVG_LOG2);
            sow_d   = 8'(sum_s_new >> AVG_LOG2);
            state_d = S_EVAL;
          end else begin
            state_d = S_COLLECT_RAIN;
          end
        end
      end
      S_EVAL: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // risk now holds what the evaluator registered at the EVAL edge.
        m_risk_d  = risk;
        m_valid_d = 1'b1;
        state_d   = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          sum_r_d   = '0;
          sum_s_d   = '0;
          cnt_d     = '0;
          state_d   = S_COLLECT_RAIN;
        end
      end
      default: begin
        state_d = S_COLLECT_RAIN;
      end
    endcase
  end

  assign s_ready   = (state_q == S_COLLECT_RAIN) || (state_q == S_COLLECT_SOIL);
  assign ef        = (state_q == S_EVAL);
  assign busy      = !((state_q == S_COLLECT_RAIN) && (cnt_q == '0));
  assign raw       = raw_q;
  assign sow       = sow_q;
  assign m_risk    = m_risk_q;
  assign m_valid   = m_valid_q;
  assign dbg_state = state_q;

`ifdef FUZZ_RISK_ALARM_EN
  logic alarm_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else if (state_q == S_CAPTURE) begin
      alarm_q <= (risk >= 8'(ALARM_LEVEL));
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm_level;

  assign unused_alarm_level = ^(8'(ALARM_LEVEL));
  assign alarm              = 1'b0;
`endif

endmodule

// File: tb/tb_fuzzy_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fuzzy_sample_sequencer
//
// Two sequencer instances: index 0 averages single pairs (AVG_LOG2=0), index 1
// averages four pairs (AVG_LOG2=2). Each has a stand-in evaluator that
// registers a step-shaped risk from raw/sow when ef is high and scrambles its
// output on every other cycle, so a capture at the wrong edge shows up.
// Inputs are driven at the falling edge; outputs are sampled at the falling
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fuzzy_sample_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data    [2];
  logic       s_valid   [2];
  logic       s_ready   [2];
  logic [7:0] raw       [2];
  logic [7:0] sow       [2];
  logic       ef        [2];
  logic [7:0] risk      [2];
  logic [7:0] m_risk    [2];
  logic       m_valid   [2];
  logic       m_ready   [2];
  logic       busy      [2];
  logic       alarm     [2];
  logic [2:0] dbg_state [2];

  int n_cmp  = 0;
  int n_fail = 0;
  int ef_cnt [2];
  logic prev_alarm [2];

  fuzzy_sample_sequencer #(.AVG_LOG2(0), .MAX_LEVEL(100), .ALARM_LEVEL(170)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .raw(raw[0]), .sow(sow[0]), .ef(ef[0]), .risk(risk[0]),
    .m_risk(m_risk[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .busy(busy[0]),
    .alarm(alarm[0]), .dbg_state(dbg_state[0])
  );

  fuzzy_sample_sequencer #(.AVG_LOG2(2), .MAX_LEVEL(100), .ALARM_LEVEL(170)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .raw(raw[1]), .sow(sow[1]), .ef(ef[1]), .risk(risk[1]),
    .m_risk(m_risk[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .busy(busy[1]),
    .alarm(alarm[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in evaluator: 80+ on both -> 255, 50+ -> 170, 20+ -> 85, else 0.
  function automatic logic [7:0] eval_risk(input logic [7:0] r, input logic [7:0] s);
    if (r >= 8'd80 && s >= 8'd80)      return 8'd255;
    else if (r >= 8'd50 && s >= 8'd50) return 8'd170;
    else if (r >= 8'd20 && s >= 8'd20) return 8'd85;
    else                               return 8'd0;
  endfunction

  function automatic logic exp_alarm(input logic [7:0] r);
`ifdef FUZZ_RISK_ALARM_EN
    return (r >= 8'd170);
`else
    return (r != r);
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      risk[0] <= 8'd0;
      risk[1] <= 8'd0;
    end else begin
      risk[0] <= ef[0] ? eval_risk(raw[0], sow[0]) : (risk[0] ^ 8'h5A);
      risk[1] <= ef[1] ? eval_risk(raw[1], sow[1]) : (risk[1] ^ 8'h5A);
    end
    if (ef[0]) ef_cnt[0] = ef_cnt[0] + 1;
    if (ef[1]) ef_cnt[1] = ef_cnt[1] + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input int u, input logic [7:0] b);
    @(negedge clk);
    s_valid[u] = 1'b1;
    s_data[u]  = b;
    n_cmp++; if (s_ready[u] !== 1'b1) begin n_fail++; $display("FAIL s_ready_collect[%0d]: got %b want 1", u, s_ready[u]); end
    @(posedge clk);
    #1 s_valid[u] = 1'b0;
  endtask

  // Called right after the edge that accepted the final soil byte.
  task automatic finish_eval(input int u, input logic [7:0] e_raw, input logic [7:0] e_sow,
                             input logic [7:0] e_risk, input int hold);
    @(negedge clk);  // EVAL
    n_cmp++; if (ef[u] !== 1'b1) begin n_fail++; $display("FAIL ef_eval[%0d]: got %b want 1", u, ef[u]); end
    n_cmp++; if (raw[u] !== e_raw) begin n_fail++; $display("FAIL raw[%0d]: got %0d want %0d", u, raw[u], e_raw); end
    n_cmp++; if (sow[u] !== e_sow) begin n_fail++; $display("FAIL sow[%0d]: got %0d want %0d", u, sow[u], e_sow); end
    n_cmp++; if (s_ready[u] !== 1'b0) begin n_fail++; $display("FAIL s_ready_eval[%0d]: got %b want 0", u, s_ready[u]); end
    n_cmp++; if (m_valid[u] !== 1'b0) begin n_fail++; $display("FAIL m_valid_eval[%0d]: got %b want 0", u, m_valid[u]); end
    n_cmp++; if (busy[u] !== 1'b1) begin n_fail++; $display("FAIL busy_eval[%0d]: got %b want 1", u, busy[u]); end
    n_cmp++; if (alarm[u] !== prev_alarm[u]) begin n_fail++; $display("FAIL alarm_hold[%0d]: got %b want %b", u, alarm[u], prev_alarm[u]); end
    @(negedge clk);  // CAPTURE
    n_cmp++; if (ef[u] !== 1'b0) begin n_fail++; $display("FAIL ef_capture[%0d]: got %b want 0", u, ef[u]); end
    n_cmp++; if (m_valid[u] !== 1'b0) begin n_fail++; $display("FAIL m_valid_early[%0d]: got %b want 0", u, m_valid[u]); end
    n_cmp++; if (s_ready[u] !== 1'b0) begin n_fail++; $display("FAIL s_ready_capture[%0d]: got %b want 0", u, s_ready[u]); end
    @(negedge clk);  // OUTPUT: second edge after the soil accept
    n_cmp++; if (m_valid[u] !== 1'b1) begin n_fail++; $display("FAIL m_valid_rise[%0d]: got %b want 1", u, m_valid[u]); end
    n_cmp++; if (m_risk[u] !== e_risk) begin n_fail++; $display("FAIL m_risk[%0d]: got %0d want %0d", u, m_risk[u], e_risk); end
    n_cmp++; if (alarm[u] !== exp_alarm(e_risk)) begin n_fail++; $display("FAIL alarm[%0d]: got %b want %b", u, alarm[u], exp_alarm(e_risk)); end
    n_cmp++; if (ef[u] !== 1'b0) begin n_fail++; $display("FAIL ef_output[%0d]: got %b want 0", u, ef[u]); end
    for (int i = 0; i < hold; i++) begin
      s_valid[u] = 1'b1;  // offered but must not be taken
      s_data[u]  = 8'd33;
      @(negedge clk);
      n_cmp++; if (m_valid[u] !== 1'b1) begin n_fail++; $display("FAIL m_valid_hold[%0d]: got %b want 1", u, m_valid[u]); end
      n_cmp++; if (m_risk[u] !== e_risk) begin n_fail++; $display("FAIL m_risk_hold[%0d]: got %0d want %0d", u, m_risk[u], e_risk); end
      n_cmp++; if (s_ready[u] !== 1'b0) begin n_fail++; $display("FAIL s_ready_hold[%0d]: got %b want 0", u, s_ready[u]); end
    end
    s_valid[u] = 1'b0;
    m_ready[u] = 1'b1;
    @(posedge clk);
    #1 m_ready[u] = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_valid[u] !== 1'b0) begin n_fail++; $display("FAIL m_valid_drop[%0d]: got %b want 0", u, m_valid[u]); end
    n_cmp++; if (busy[u] !== 1'b0) begin n_fail++; $display("FAIL busy_idle[%0d]: got %b want 0", u, busy[u]); end
    n_cmp++; if (s_ready[u] !== 1'b1) begin n_fail++; $display("FAIL s_ready_idle[%0d]: got %b want 1", u, s_ready[u]); end
    prev_alarm[u] = exp_alarm(e_risk);
  endtask

  task automatic single_pair(input logic [7:0] r, input logic [7:0] s, input logic [7:0] e_avg_r,
                             input logic [7:0] e_avg_s, input logic [7:0] e_risk, input int hold);
    int ef0;
    ef0 = ef_cnt[0];
    send_byte(0, r);
    send_byte(0, s);
    finish_eval(0, e_avg_r, e_avg_s, e_risk, hold);
    n_cmp++; if (ef_cnt[0] - ef0 !== 1) begin n_fail++; $display("FAIL ef_count[0]: got %0d want 1", ef_cnt[0] - ef0); end
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_cmp++; if (raw[u] !== 8'd0 || sow[u] !== 8'd0) begin n_fail++; $display("FAIL reset_avg[%0d]: got %0d/%0d want 0/0", u, raw[u], sow[u]); end
      n_cmp++; if (m_risk[u] !== 8'd0) begin n_fail++; $display("FAIL reset_m_risk[%0d]: got %0d want 0", u, m_risk[u]); end
      n_cmp++; if (ef[u] !== 1'b0 || m_valid[u] !== 1'b0 || alarm[u] !== 1'b0) begin n_fail++; $display("FAIL reset_flags[%0d]: got ef=%b mv=%b al=%b want 0", u, ef[u], m_valid[u], alarm[u]); end
      n_cmp++; if (busy[u] !== 1'b0 || s_ready[u] !== 1'b1) begin n_fail++; $display("FAIL reset_idle[%0d]: got busy=%b rdy=%b want 0/1", u, busy[u], s_ready[u]); end
      n_cmp++; if (dbg_state[u] !== 3'd0) begin n_fail++; $display("FAIL reset_state[%0d]: got %0d want 0", u, dbg_state[u]); end
    end
  endtask

  task automatic test_single_pair();
    single_pair(8'd80, 8'd80, 8'd80, 8'd80, 8'd255, 0);
  endtask

  task automatic test_risk_levels();
    single_pair(8'd50, 8'd50, 8'd50, 8'd50, 8'd170, 0);
    single_pair(8'd20, 8'd20, 8'd20, 8'd20, 8'd85, 0);
    single_pair(8'd0,  8'd0,  8'd0,  8'd0,  8'd0, 0);
  endtask

  task automatic test_average4();
    int ef0;
    logic [7:0] rs [4];
    logic [7:0] ss [4];
    rs = '{8'd70, 8'd90, 8'd80, 8'd80};
    ss = '{8'd80, 8'd80, 8'd80, 8'd80};
    ef0 = ef_cnt[1];
    for (int p = 0; p < 4; p++) begin
      send_byte(1, rs[p]);
      send_byte(1, ss[p]);
      if (p < 3) begin
        @(negedge clk);  // idle cycle between pairs
        n_cmp++; if (ef[1] !== 1'b0) begin n_fail++; $display("FAIL ef_partial[1]: got %b want 0 after pair %0d", ef[1], p); end
        n_cmp++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL busy_partial[1]: got %b want 1 after pair %0d", busy[1], p); end
      end
    end
    finish_eval(1, 8'd80, 8'd80, 8'd255, 0);
    n_cmp++; if (ef_cnt[1] - ef0 !== 1) begin n_fail++; $display("FAIL ef_count[1]: got %0d want 1", ef_cnt[1] - ef0); end
  endtask

  task automatic test_saturate_hold();
    single_pair(8'd200, 8'd255, 8'd100, 8'd100, 8'd255, 5);
  endtask

  task automatic test_reset_midstream();
    int ef0;
    send_byte(1, 8'd100);
    send_byte(1, 8'd100);
    send_byte(1, 8'd100);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    prev_alarm[0] = 1'b0;
    prev_alarm[1] = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL busy_after_reset[1]: got %b want 0", busy[1]); end
    n_cmp++; if (raw[1] !== 8'd0 || sow[1] !== 8'd0) begin n_fail++; $display("FAIL avg_after_reset[1]: got %0d/%0d want 0/0", raw[1], sow[1]); end
    ef0 = ef_cnt[1];
    for (int p = 0; p < 4; p++) begin
      send_byte(1, 8'd50);
      send_byte(1, 8'd50);
    end
    finish_eval(1, 8'd50, 8'd50, 8'd170, 0);
    n_cmp++; if (ef_cnt[1] - ef0 !== 1) begin n_fail++; $display("FAIL ef_count_reset[1]: got %0d want 1", ef_cnt[1] - ef0); end
  endtask

  task automatic test_alarm();
    single_pair(8'd80, 8'd80, 8'd80, 8'd80, 8'd255, 0);
    single_pair(8'd20, 8'd20, 8'd20, 8'd20, 8'd85, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      s_data[u] = 8'd0; s_valid[u] = 1'b0; m_ready[u] = 1'b0;
      ef_cnt[u] = 0; prev_alarm[u] = 1'b0;
    end
    test_reset();
    test_single_pair();
    test_risk_levels();
    test_average4();
    test_saturate_hold();
    test_reset_midstream();
    test_alarm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
